lsu32: RTL

LSU32 -- requirements
Module: lsu32

---
 rtl/core_pkg.sv | 32 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu32.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, LSU state encoding, RV32I load/store funct3 values.
package core_pkg;

    localparam int unsigned Xlen = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    localparam logic [2:0] LsB  = 3'b000;
    localparam logic [2:0] LsH  = 3'b001;
    localparam logic [2:0] LsW  = 3'b010;
    localparam logic [2:0] LsBu = 3'b100;
    localparam logic [2:0] LsHu = 3'b101;

    // Size class comes from funct3[1:0]; encodings 3, 6 and 7 fall into the word class.
    function automatic logic is_byte(input logic [1:0] size);
        return size == 2'b00;
    endfunction

    function automatic logic is_half(input logic [1:0] size);
        return size == 2'b01;
    endfunction

    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte mask, store lane replication and
// load data extraction with sign/zero extension.
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic [Xlen-1:0] wdata_i,
    input  logic [Xlen-1:0] rdata_i,
    output logic [3:0]      wmask_o,
    output logic [Xlen-1:0] wdata_o,
    output logic [Xlen-1:0] rdata_o
);

    logic [Xlen-1:0] rshift;

    // Store side: mask selects the written lanes, data is replicated into every lane.
    always_comb begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        if (is_byte(funct3_i[1:0])) begin
            wmask_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
        end else if (is_half(funct3_i[1:0])) begin
            wmask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
        end
    end

    // Load side: right-justify the addressed bytes, then extend by funct3.
    always_comb begin
        rshift  = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = rshift;
        case (funct3_i)
            LsB:     rdata_o = {{(Xlen-8){rshift[7]}}, rshift[7:0]};
            LsH:     rdata_o = {{(Xlen-16){rshift[15]}}, rshift[15:0]};
            LsBu:    rdata_o = {{(Xlen-8){1'b0}}, rshift[7:0]};
            LsHu:    rdata_o = {{(Xlen-16){1'b0}}, rshift[15:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/lsu32.sv
// Single-outstanding load/store unit. One request is accepted in Idle, issued on the
// memory channel, and (for loads, or stores when StoreResp) answered on the result channel.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned accesses return an error
// response without touching memory; when undefined they are forced to natural alignment.
module lsu32
    import core_pkg::*;
#(
    parameter bit StoreResp = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [Xlen-1:0] addr_i,
    input  logic [Xlen-1:0] wdata_i,
    input  logic [2:0]      funct3_i,
    input  logic            store_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [Xlen-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_wmask_o,
    output logic [Xlen-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [Xlen-1:0] mem_rdata_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [Xlen-1:0] resp_data_o,
    output logic            resp_err_o
);

    lsu_state_e      state_q, state_d;
    logic [Xlen-1:0] addr_q, addr_d;
    logic [Xlen-1:0] wdata_q, wdata_d;
    logic [Xlen-1:0] rdata_q, rdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            store_q, store_d;
    logic [3:0]      wmask;
    logic [Xlen-1:0] wdata_lane;
    logic [Xlen-1:0] rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic misaligned;

    assign misaligned = (is_half(funct3_i[1:0]) && addr_i[0]) ||
                        (is_word(funct3_i[1:0]) && (addr_i[1:0] != 2'b00));
    assign resp_err_o = err_q;
`else
    logic [Xlen-1:0] addr_fixed;

    // Misaligned halves/words silently drop the low address bits.
    assign addr_fixed = is_word(funct3_i[1:0]) ? {addr_i[Xlen-1:2], 2'b00} :
                        is_half(funct3_i[1:0]) ? {addr_i[Xlen-1:1], 1'b0}  : addr_i;
    assign resp_err_o = 1'b0;
`endif

    lsu_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata_i),
        .wmask_o   (wmask),
        .wdata_o   (wdata_lane),
        .rdata_o   (rdata_ext)
    );

    // Next-state logic: capture on request, advance on each channel handshake.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        store_d  = store_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    wdata_d  = wdata_i;
                    funct3_d = funct3_i;
                    store_d  = store_i;
                    rdata_d  = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d   = addr_i;
                    err_d    = misaligned;
                    state_d  = misaligned ? StResp : StReq;
`else
                    addr_d   = addr_fixed;
                    state_d  = StReq;
`endif
                end
            end
            StReq: begin
                if (mem_ready_i) begin
                    if (!store_q)      state_d = StWait;
                    else if (StoreResp) state_d = StResp;
                    else               state_d = StIdle;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    rdata_d = rdata_ext;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign mem_valid_o  = (state_q == StReq);
    assign mem_addr_o   = {addr_q[Xlen-1:2], 2'b00};
    assign mem_we_o     = store_q;
    assign mem_wmask_o  = mem_valid_o ? wmask : 4'b0000;
    assign mem_wdata_o  = wdata_lane;
    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = rdata_q;

endmodule
